// File: rtl/isa_io_bridge.sv
// ISA I/O front end: synchronises the raw bus, decodes the SB/FM/MPU/joystick
// windows and turns IOR_N/IOW_N cycles into filtered one-clock strobes with read-back drive.
module isa_io_bridge #(
  parameter logic [15:0] SB_BASE  = 16'h0220,
  parameter logic [15:0] FM_BASE  = 16'h0388,
  parameter logic [15:0] MPU_BASE = 16'h0330,
  parameter logic [15:0] JOY_BASE = 16'h0201,
  parameter int          FILT     = 2,
  parameter int          RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isa_ior_n,
  input  logic        isa_iow_n,
  input  logic        isa_bale,
  input  logic        isa_aen,
  input  logic [15:0] isa_sa,
  input  logic [7:0]  isa_sd_in,
  output logic [7:0]  isa_sd_out,
  output logic        isa_sd_oe,
  output logic        isa_sd_dir_n,
  output logic [3:0]  io_addr,
  output logic [7:0]  io_writedata,
  output logic        io_write,
  output logic        io_read,
  input  logic [7:0]  io_readdata,
  output logic        sb_cs,
  output logic        fm_cs,
  output logic        mpu_cs,
  output logic        joy_cs
);

  localparam logic [2:0] FILT_C   = 3'(FILT);
  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE,
    WR_FILT,
    WR_HOLD,
    RD_FILT,
    RD_WAIT,
    RD_DRIVE
  } state_t;

  logic        ior_m, ior_s, iow_m, iow_s;
  logic        bale_m, bale_s, aen_m, aen_s;
  logic [15:0] sa_r;
  logic [7:0]  sd_r;

  // Stage: two-flop synchronisers for control, single register for buses
  always_ff @(posedge clk) begin
    ior_m  <= isa_ior_n;
    ior_s  <= ior_m;
    iow_m  <= isa_iow_n;
    iow_s  <= iow_m;
    bale_m <= isa_bale;
    bale_s <= bale_m;
    aen_m  <= isa_aen;
    aen_s  <= aen_m;
    sa_r   <= isa_sa;
    sd_r   <= isa_sd_in;
  end

  logic [15:0] addr_lat;
  logic [15:0] sb_off, fm_off, mpu_off;
  logic        any_cs;

  assign sb_off  = addr_lat - SB_BASE;
  assign fm_off  = addr_lat - FM_BASE;
  assign mpu_off = addr_lat - MPU_BASE;
  assign any_cs  = sb_cs | fm_cs | mpu_cs | joy_cs;
  assign io_addr = addr_lat[3:0];

  // Stage: address latch, then registered window decode one clock behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_lat <= '0;
      sb_cs    <= 1'b0;
      fm_cs    <= 1'b0;
      mpu_cs   <= 1'b0;
      joy_cs   <= 1'b0;
    end else begin
      if (bale_s) addr_lat <= sa_r;
      sb_cs  <= (sb_off  < 16'd16);
      fm_cs  <= (fm_off  < 16'd4);
      mpu_cs <= (mpu_off < 16'd2);
      joy_cs <= (addr_lat == JOY_BASE);
    end
  end

  // A strobe still low when reset is released must go high before it counts.
  logic armed;
  always_ff @(posedge clk) begin
    if (reset)               armed <= 1'b0;
    else if (ior_s && iow_s) armed <= 1'b1;
  end

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       wr_fire, rd_fire, rd_cap, rd_rel;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    rd_cap   = 1'b0;
    rd_rel   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (armed && !aen_s && any_cs) begin
          if (!iow_s && ior_s)      state_nx = WR_FILT;
          else if (!ior_s && iow_s) state_nx = RD_FILT;
        end
      end
      WR_FILT: begin
        if (iow_s || aen_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt + 3'd1 == FILT_C) begin
          wr_fire  = 1'b1;
          state_nx = WR_HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      WR_HOLD: begin
        if (iow_s) state_nx = IDLE;
      end
      RD_FILT: begin
        if (ior_s || aen_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt + 3'd1 == FILT_C) begin
          rd_fire  = 1'b1;
          state_nx = RD_WAIT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      RD_WAIT: begin
        // An early IOR release wins over a capture due in the same clock.
        if (ior_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt + 3'd1 == RD_LAT_C) begin
          rd_cap   = 1'b1;
          state_nx = RD_DRIVE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      RD_DRIVE: begin
        if (ior_s) begin
          rd_rel   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  logic sd_oe;

  // Stage: state register and registered strobes / drive outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      io_write     <= 1'b0;
      io_read      <= 1'b0;
      io_writedata <= '0;
      isa_sd_out   <= '0;
      sd_oe        <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      io_write <= wr_fire;
      io_read  <= rd_fire;
      if (wr_fire) io_writedata <= sd_r;
      if (rd_cap)  isa_sd_out   <= io_readdata;
      if (rd_cap)      sd_oe <= 1'b1;
      else if (rd_rel) sd_oe <= 1'b0;
    end
  end

  // Direction is derived from the enable so the two can never disagree.
  assign isa_sd_oe    = sd_oe;
  assign isa_sd_dir_n = ~sd_oe;

endmodule

// File: tb/tb_isa_io_bridge.sv
// Bench for isa_io_bridge: table of ISA cycles, a reset-mid-read sequence and
// random cycles predicted from the bus timing rules (window, AEN, filter length).
module tb_isa_io_bridge;

  localparam int FILT   = 2;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        isa_ior_n, isa_iow_n, isa_bale, isa_aen;
  logic [15:0] isa_sa;
  logic [7:0]  isa_sd_in;
  logic [7:0]  isa_sd_out;
  logic        isa_sd_oe, isa_sd_dir_n;
  logic [3:0]  io_addr;
  logic [7:0]  io_writedata;
  logic        io_write, io_read;
  logic [7:0]  io_readdata;
  logic        sb_cs, fm_cs, mpu_cs, joy_cs;

  always #5 clk = ~clk;

  isa_io_bridge #(.FILT(FILT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n), .isa_bale(isa_bale), .isa_aen(isa_aen),
    .isa_sa(isa_sa), .isa_sd_in(isa_sd_in),
    .isa_sd_out(isa_sd_out), .isa_sd_oe(isa_sd_oe), .isa_sd_dir_n(isa_sd_dir_n),
    .io_addr(io_addr), .io_writedata(io_writedata), .io_write(io_write), .io_read(io_read),
    .io_readdata(io_readdata),
    .sb_cs(sb_cs), .fm_cs(fm_cs), .mpu_cs(mpu_cs), .joy_cs(joy_cs)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    logic [7:0]  data;
    int          low;      // clocks the raw strobe is held low
    bit          aen;
    logic [7:0]  rdata;
    logic [3:0]  exp_cs;   // {sb, fm, mpu, joy}
    bit          exp_wr;
    bit          exp_rd;
    bit          exp_drive;
  } vec_t;

  logic [15:0] picks [16] = '{16'h021F, 16'h0220, 16'h0225, 16'h022F, 16'h0230, 16'h0387,
                              16'h0388, 16'h038B, 16'h038C, 16'h032F, 16'h0330, 16'h0331,
                              16'h0332, 16'h0200, 16'h0201, 16'h0202};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] win(input logic [15:0] a);
    logic sb, fm, mpu, joy;
    sb  = (a >= 16'h0220) && (a <= 16'h022F);
    fm  = (a >= 16'h0388) && (a <= 16'h038B);
    mpu = (a == 16'h0330) || (a == 16'h0331);
    joy = (a == 16'h0201);
    return {sb, fm, mpu, joy};
  endfunction

  // Strobe fires when the low run covers the filter; drive needs filter + latency too.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    logic hit;
    r = v;
    r.exp_cs    = win(v.addr);
    hit         = (r.exp_cs != 4'b0) && !v.aen;
    r.exp_wr    = hit && v.wr  && (v.low >= FILT + 1);
    r.exp_rd    = hit && !v.wr && (v.low >= FILT + 1);
    r.exp_drive = r.exp_rd && (v.low >= FILT + RD_LAT + 1);
    return r;
  endfunction

  task automatic bale_phase(input logic [15:0] addr);
    @(negedge clk);
    isa_sa   = addr;
    isa_bale = 1'b1;
    repeat (2) @(negedge clk);
    isa_bale = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_cycle(input vec_t v, input string tag);
    int wr_cnt, wr_idx, rd_cnt, rd_idx, oe_cnt, oe_idx, bad_sd, conflict;
    logic [7:0] wdata;
    wr_cnt = 0; wr_idx = -1; rd_cnt = 0; rd_idx = -1;
    oe_cnt = 0; oe_idx = -1; bad_sd = 0; conflict = 0; wdata = 8'h00;
    bale_phase(v.addr);
    check({tag, ".cs"}, {28'h0, sb_cs, fm_cs, mpu_cs, joy_cs}, {28'h0, v.exp_cs});
    check({tag, ".io_addr"}, {28'h0, io_addr}, {28'h0, v.addr[3:0]});
    isa_sd_in   = v.data;
    io_readdata = v.rdata;
    isa_aen     = v.aen;
    if (v.wr) isa_iow_n = 1'b0;
    else      isa_ior_n = 1'b0;
    // Sample index k reflects the outputs after the k-th edge since the strobe fell.
    for (int k = 0; k < v.low + 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (io_write === 1'b1) begin
        wr_cnt++;
        if (wr_idx < 0) begin wr_idx = k; wdata = io_writedata; end
      end
      if (io_read === 1'b1) begin
        rd_cnt++;
        if (rd_idx < 0) rd_idx = k;
      end
      if (isa_sd_oe === 1'b1) begin
        oe_cnt++;
        if (oe_idx < 0) oe_idx = k;
        if (isa_sd_out !== v.rdata) bad_sd++;
      end
      if (isa_sd_dir_n !== ~isa_sd_oe) conflict++;
      if (k == v.low - 1) begin
        isa_iow_n = 1'b1;
        isa_ior_n = 1'b1;
      end
    end
    isa_aen = 1'b0;
    check({tag, ".wr_pulses"}, wr_cnt, v.exp_wr ? 1 : 0);
    check({tag, ".rd_pulses"}, rd_cnt, v.exp_rd ? 1 : 0);
    check({tag, ".oe_clocks"}, oe_cnt, v.exp_drive ? v.low - FILT - RD_LAT : 0);
    check({tag, ".oe_dir_conflict"}, conflict, 0);
    check({tag, ".sd_out"}, bad_sd, 0);
    if (v.exp_wr) begin
      check({tag, ".wr_latency"}, wr_idx, 2 + FILT);
      check({tag, ".writedata"}, {24'h0, wdata}, {24'h0, v.data});
    end
    if (v.exp_rd) check({tag, ".rd_latency"}, rd_idx, 2 + FILT);
    if (v.exp_drive) check({tag, ".oe_latency"}, oe_idx, 2 + FILT + RD_LAT);
  endtask

  vec_t tbl [12];

  initial begin
    vec_t v;
    int   rd_seen;

    tbl[0]  = '{16'h0388, 1'b1, 8'h5A, 10, 1'b0, 8'h00, 4'b0100, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{16'h022A, 1'b0, 8'h00, 12, 1'b0, 8'hAA, 4'b1000, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{16'h0220, 1'b1, 8'h11, 1,  1'b0, 8'h00, 4'b1000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{16'h0300, 1'b1, 8'h22, 8,  1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{16'h0220, 1'b1, 8'h33, 8,  1'b1, 8'h00, 4'b1000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'h0331, 1'b0, 8'h00, 4,  1'b0, 8'h99, 4'b0010, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{16'h0201, 1'b0, 8'h00, 6,  1'b0, 8'h3C, 4'b0001, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{16'h038B, 1'b1, 8'hC3, 3,  1'b0, 8'h00, 4'b0100, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{16'h038C, 1'b1, 8'h44, 8,  1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{16'h022F, 1'b0, 8'h00, 5,  1'b0, 8'h81, 4'b1000, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{16'h0230, 1'b0, 8'h00, 8,  1'b0, 8'h55, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{16'h0220, 1'b1, 8'h66, 2,  1'b0, 8'h00, 4'b1000, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; isa_ior_n = 1'b1; isa_iow_n = 1'b1; isa_bale = 1'b0; isa_aen = 1'b0;
    isa_sa = 16'h0000; isa_sd_in = 8'h00; io_readdata = 8'h00;
    repeat (5) @(negedge clk);
    check("rst.sd_out", {24'h0, isa_sd_out}, 32'h0);
    check("rst.sd_oe", {31'h0, isa_sd_oe}, 32'h0);
    check("rst.sd_dir_n", {31'h0, isa_sd_dir_n}, 32'h1);
    check("rst.io_write", {31'h0, io_write}, 32'h0);
    check("rst.io_read", {31'h0, io_read}, 32'h0);
    check("rst.writedata", {24'h0, io_writedata}, 32'h0);
    check("rst.io_addr", {28'h0, io_addr}, 32'h0);
    check("rst.cs", {28'h0, sb_cs, fm_cs, mpu_cs, joy_cs}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) do_cycle(tbl[i], $sformatf("tbl%0d", i));

    // Reset while driving a read; the still-low IOR_N must not start a new read.
    bale_phase(16'h0201);
    io_readdata = 8'h77;
    isa_ior_n   = 1'b0;
    for (int k = 0; k <= 2 + FILT + RD_LAT; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rstrd.driving", {31'h0, isa_sd_oe}, 32'h1);
    check("rstrd.drive_data", {24'h0, isa_sd_out}, 32'h77);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstrd.sd_oe", {31'h0, isa_sd_oe}, 32'h0);
    check("rstrd.sd_dir_n", {31'h0, isa_sd_dir_n}, 32'h1);
    check("rstrd.cs", {28'h0, sb_cs, fm_cs, mpu_cs, joy_cs}, 32'h0);
    check("rstrd.sd_out", {24'h0, isa_sd_out}, 32'h0);
    reset = 1'b0;
    rd_seen = 0;
    @(negedge clk);
    isa_sa   = 16'h0201;
    isa_bale = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 1) isa_bale = 1'b0;
      if (io_read === 1'b1) rd_seen++;
    end
    check("rstrd.joy_cs", {31'h0, joy_cs}, 32'h1);
    check("rstrd.no_read_while_low", rd_seen, 0);
    isa_ior_n = 1'b1;
    repeat (4) @(negedge clk);
    v = '{16'h0201, 1'b0, 8'h00, 7, 1'b0, 8'h5C, 4'b0001, 1'b0, 1'b1, 1'b1};
    do_cycle(v, "rstrd.next");

    for (int i = 0; i < 30; i++) begin
      v.addr  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : picks[$urandom_range(0, 15)];
      v.wr    = 1'($urandom_range(0, 1));
      v.data  = 8'($urandom);
      v.low   = $urandom_range(1, 10);
      v.aen   = ($urandom_range(0, 5) == 0);
      v.rdata = 8'($urandom);
      v = predict(v);
      do_cycle(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/isa_io_bridge.md
Name: isa_io_bridge

Overview:
ISA-side I/O front end of the sound card top level. It samples the raw asynchronous ISA I/O signals, latches the port address on BALE, and decodes the SB (0x220-0x22F), FM (0x388-0x38B), MPU (0x330) and joystick (0x201) windows. It converts IOR_N/IOW_N cycles into single-clock read/write strobes for the `sound` core, captures the returned byte, and drives it onto SD[7:0] with the transceiver direction control. It replaces the ad-hoc level-sensitive strobe logic at the top level with glitch-filtered, one-shot handshakes.

Parameters:
SB_BASE, 16'h0220, base of 16-port SB window (base..base+15)
FM_BASE, 16'h0388, base of 4-port FM window (base..base+3)
MPU_BASE, 16'h0330, MPU port (base, base+1)
JOY_BASE, 16'h0201, single joystick port
FILT, 2, consecutive synchronised-low cycles required on IOR_N/IOW_N (1..7)
RD_LAT, 2, clocks from io_read pulse to io_readdata capture (1..7)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high
isa_ior_n  in  1  raw ISA IOR_N, async
isa_iow_n  in  1  raw ISA IOW_N, async
isa_bale  in  1  raw ISA BALE, async
isa_aen  in  1  raw ISA AEN, async (high = DMA cycle)
isa_sa  in  16  raw ISA SA[15:0]
isa_sd_in  in  8  raw ISA SD[7:0]
isa_sd_out  out  8  read data to drive onto SD[7:0]
isa_sd_oe  out  1  1 = drive SD[7:0]
isa_sd_dir_n  out  1  SD70_DIR; 0 = FPGA->ISA, 1 = ISA->FPGA
io_addr  out  4  latched address [3:0]
io_writedata  out  8  write byte, valid while io_write is high
io_write  out  1  one-clock write strobe
io_read  out  1  one-clock read strobe
io_readdata  in  8  byte returned by the sound/mpu/joy mux
sb_cs, fm_cs, mpu_cs, joy_cs  out  1 each  registered window decodes

Behaviour:
- Synchronisers: ior_n, iow_n, bale and aen each pass through 2 flops (suffix _s). SA and SD pass through 1 register stage, aligned with the second sync stage.
- Address latch: addr_lat follows the SA register every clock while bale_s=1 and holds while bale_s=0. The cs outputs are decoded from addr_lat and registered, so they update 1 clock after addr_lat. io_addr = addr_lat[3:0].
- any_cs = sb_cs|fm_cs|mpu_cs|joy_cs.
- FSM states: IDLE, WR_FILT, WR_HOLD, RD_FILT, RD_WAIT, RD_DRIVE.
  - IDLE: go to WR_FILT when iow_s=0, ior_s=1, aen_s=0 and any_cs. Go to RD_FILT under the same condition with ior_s/iow_s swapped. If both strobes are low, stay in IDLE.
  - WR_FILT: a counter counts consecutive iow_s=0 cycles. If iow_s=1 or aen_s=1 before the count reaches FILT, return to IDLE with no strobe. When the count reaches FILT, pulse io_write for 1 clock and latch io_writedata from the SD register in the same clock; next state WR_HOLD.
  - WR_HOLD: stay until iow_s=1, then go to IDLE. Exactly one io_write per IOW cycle.
  - RD_FILT: same filter rule on ior_s. At count FILT, pulse io_read for 1 clock; next state RD_WAIT.
  - RD_WAIT: count RD_LAT clocks from the io_read clock, then capture io_readdata into isa_sd_out, set isa_sd_oe=1 and isa_sd_dir_n=0; next state RD_DRIVE. If ior_s rises during RD_WAIT, abort to IDLE without driving.
  - RD_DRIVE: hold the drive until ior_s=1. In the clock that ior_s=1 is seen, deassert isa_sd_oe and set isa_sd_dir_n=1; go to IDLE.
- Latency: io_write/io_read is asserted 2+FILT clocks after the first clk edge that samples the raw strobe low.
- Reset (any state, including mid-cycle) forces these values and the FSM to IDLE:
  - isa_sd_out=0, isa_sd_oe=0, isa_sd_dir_n=1
  - io_write=0, io_read=0, io_writedata=0
  - addr_lat=0, all cs=0, filter/latency counters=0
- After reset, a strobe that is already low must first return high (pass through IDLE) before it can start a new cycle; no strobe is issued for it.
- isa_sd_oe and isa_sd_dir_n always change in the same clock and are never in conflicting states (oe=1 implies dir_n=0).
- Addresses outside all windows produce no strobes and no drive.

Test Plan:
- Write: BALE pulse with SA=0x0388, then IOW_N low for 10 clocks with SD=0x5A and AEN=0 -> fm_cs=1, one io_write pulse 4 clocks after IOW_N fall (FILT=2), io_addr=0x8, io_writedata=0x5A; no second pulse.
- Read: SA=0x022A, IOR_N low for 12 clocks, io_readdata=0xAA -> io_read 1 clock, then isa_sd_oe=1, isa_sd_dir_n=0, isa_sd_out=0xAA 2 clocks later; all released 1 clock after ior_s rises.
- Glitch: IOW_N low for 1 clock at SA=0x0220 -> no io_write; FSM back to IDLE.
- Unmapped/DMA: SA=0x0300 IOW cycle -> no strobe. SA=0x0220 with AEN=1 -> no strobe.
- Early read abort: ior_s rises during RD_WAIT (RD_LAT=4) -> isa_sd_oe stays 0; next read at 0x0201 works, joy_cs=1.
- Reset mid-read in RD_DRIVE -> next clock isa_sd_oe=0, dir_n=1, cs=0; IOR_N still low after reset -> no io_read until it goes high and low again.
